// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, millisecond-tick debounce per pin,
// press/release pulses and a single-button press event for the game FSM.
module btn_debounce #(
    parameter int NUM_BTN     = 4,
    parameter int DEBOUNCE_MS = 10,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         ticks_per_milli,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn,
    output logic [NUM_BTN-1:0] press,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic               press_valid,
    output logic [1:0]         press_idx,
    output logic               chord
);

    localparam logic [NUM_BTN-1:0] IDLE_LEVEL = {NUM_BTN{ACTIVE_LOW}};
    localparam logic [7:0]         DB_LAST    = 8'(DEBOUNCE_MS - 1);

    typedef enum logic [1:0] {IDLE, HELD, CHORD} state_t;

    logic [NUM_BTN-1:0] sync1_reg, sync2_reg, s;
    logic [5:0]         presc_reg;
    logic               tick;
    logic [NUM_BTN-1:0] btn_reg, btn_next;
    logic [NUM_BTN-1:0] press_reg, press_next;
    logic [NUM_BTN-1:0] release_reg, release_next;
    state_t             state_reg, state_next;
    logic               press_valid_reg, press_valid_next;
    logic [1:0]         press_idx_reg, press_idx_next;
    logic               chord_reg, chord_next;
    int                 n_set;

    // Synchronisers reset to the released level so reset release never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= IDLE_LEVEL;
            sync2_reg <= IDLE_LEVEL;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = sync2_reg ^ IDLE_LEVEL;

    // 6-bit compare wraps, so ticks_per_milli = 0 gives a 64-cycle millisecond.
    assign tick = (presc_reg == ticks_per_milli - 6'd1);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 6'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
        logic [7:0] cnt_reg, cnt_next;
        logic       mismatch, commit;

        assign mismatch         = s[gi] ^ btn_reg[gi];
        assign commit           = mismatch & tick & (cnt_reg == DB_LAST);
        assign btn_next[gi]     = commit ? s[gi] : btn_reg[gi];
        assign press_next[gi]   = commit & s[gi];
        assign release_next[gi] = commit & ~s[gi];

        // Any cycle where the input agrees with the committed level restarts the count.
        always_comb begin
            cnt_next = cnt_reg;
            if (!mismatch || commit) begin
                cnt_next = '0;
            end else if (tick) begin
                cnt_next = cnt_reg + 8'd1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_reg     <= '0;
            press_reg   <= '0;
            release_reg <= '0;
        end else begin
            btn_reg     <= btn_next;
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    always_comb begin
        n_set = 0;
        for (int i = 0; i < NUM_BTN; i++) begin
            n_set = n_set + int'(btn_next[i]);
        end
    end

    // Event FSM looks at the vector being committed so the event lands with btn.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            press_valid_reg <= 1'b0;
            press_idx_reg   <= '0;
            chord_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            press_valid_reg <= press_valid_next;
            press_idx_reg   <= press_idx_next;
            chord_reg       <= chord_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (n_set == 1) begin
                    state_next = HELD;
                end else if (n_set >= 2) begin
                    state_next = CHORD;
                end
            end
            HELD: begin
                if (n_set == 0) begin
                    state_next = IDLE;
                end else if (n_set >= 2) begin
                    state_next = CHORD;
                end
            end
            CHORD: begin
                if (n_set == 0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        press_valid_next = (state_reg == IDLE) && (n_set == 1);
        press_idx_next   = press_idx_reg;
        chord_next       = (n_set >= 2);
        if (press_valid_next) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_next[i]) begin
                    press_idx_next = 2'(i);
                end
            end
        end
    end

    assign btn           = btn_reg;
    assign press         = press_reg;
    assign release_pulse = release_reg;
    assign press_valid   = press_valid_reg;
    assign press_idx     = press_idx_reg;
    assign chord         = chord_reg;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: an active-high and an active-low instance share one stimulus,
// checked every cycle against a behavioural model plus directed literal checks.
module tb_btn_debounce;

    localparam int DB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] tpm = 6'd1;
    logic [3:0] raw = 4'h0;
    logic [3:0] raw_al;
    logic       cmp_en = 1'b0;

    logic [3:0] d_btn [2];
    logic [3:0] d_press [2];
    logic [3:0] d_rel [2];
    logic       d_pv [2];
    logic [1:0] d_idx [2];
    logic       d_chord [2];

    logic [3:0] m_sync1 [2];
    logic [3:0] m_sync2 [2];
    logic [3:0] m_btn [2];
    logic [3:0] m_press [2];
    logic [3:0] m_rel [2];
    logic       m_pv [2];
    logic [1:0] m_idx [2];
    logic       m_chord [2];
    int         m_run [2][4];
    int         m_n;

    int checks = 0;
    int failures = 0;

    assign raw_al = ~raw;

    always #5 clk = ~clk;

    btn_debounce #(.NUM_BTN(4), .DEBOUNCE_MS(DB), .ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst(rst), .ticks_per_milli(tpm), .btn_raw(raw),
        .btn(d_btn[0]), .press(d_press[0]), .release_pulse(d_rel[0]),
        .press_valid(d_pv[0]), .press_idx(d_idx[0]), .chord(d_chord[0])
    );

    btn_debounce #(.NUM_BTN(4), .DEBOUNCE_MS(DB), .ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst(rst), .ticks_per_milli(tpm), .btn_raw(raw_al),
        .btn(d_btn[1]), .press(d_press[1]), .release_pulse(d_rel[1]),
        .press_valid(d_pv[1]), .press_idx(d_idx[1]), .chord(d_chord[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: tick on every period-th clock since reset; a level commits once it has
    // disagreed with the committed level across DB ticks without interruption.
    task automatic model_step();
        int         per;
        bit         tk;
        logic [3:0] s, nb, pr, rl, inv;
        int         ones;
        if (rst) begin
            m_n = 0;
            for (int k = 0; k < 2; k++) begin
                m_sync1[k] = (k == 1) ? 4'hF : 4'h0;
                m_sync2[k] = (k == 1) ? 4'hF : 4'h0;
                m_btn[k] = 4'h0; m_press[k] = 4'h0; m_rel[k] = 4'h0;
                m_pv[k] = 1'b0; m_idx[k] = 2'd0; m_chord[k] = 1'b0;
                for (int c = 0; c < 4; c++) m_run[k][c] = 0;
            end
        end else begin
            m_n++;
            per = (tpm == 6'd0) ? 64 : int'(tpm);
            tk = ((m_n % per) == 0);
            for (int k = 0; k < 2; k++) begin
                inv = (k == 1) ? 4'hF : 4'h0;
                s = m_sync2[k] ^ inv;
                nb = m_btn[k]; pr = 4'h0; rl = 4'h0;
                for (int c = 0; c < 4; c++) begin
                    if (s[c] == m_btn[k][c]) begin
                        m_run[k][c] = 0;
                    end else if (tk) begin
                        m_run[k][c]++;
                        if (m_run[k][c] == DB) begin
                            nb[c] = s[c];
                            m_run[k][c] = 0;
                            if (s[c]) pr[c] = 1'b1; else rl[c] = 1'b1;
                        end
                    end
                end
                ones = $countones(nb);
                m_pv[k] = (m_btn[k] == 4'h0) && (ones == 1);
                if (m_pv[k]) begin
                    for (int c = 0; c < 4; c++) if (nb[c]) m_idx[k] = 2'(c);
                end
                m_chord[k] = (ones >= 2);
                m_press[k] = pr; m_rel[k] = rl; m_btn[k] = nb;
                m_sync2[k] = m_sync1[k];
                m_sync1[k] = raw ^ inv;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("m%0d_btn", k),   32'(d_btn[k]),   32'(m_btn[k]));
                check($sformatf("m%0d_press", k), 32'(d_press[k]), 32'(m_press[k]));
                check($sformatf("m%0d_rel", k),   32'(d_rel[k]),   32'(m_rel[k]));
                check($sformatf("m%0d_pv", k),    32'(d_pv[k]),    32'(m_pv[k]));
                check($sformatf("m%0d_idx", k),   32'(d_idx[k]),   32'(m_idx[k]));
                check($sformatf("m%0d_chord", k), 32'(d_chord[k]), 32'(m_chord[k]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [5:0] t);
        rst = 1'b1; tpm = t; raw = 4'h0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int lat, pc, pvc, hold;
        step(2);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Reset state and quiet period, both polarities
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_hi", {d_btn[0], d_press[0], d_rel[0], d_pv[0], d_idx[0], d_chord[0]}, 32'h0);
            check("idle_lo", {d_btn[1], d_press[1], d_rel[1], d_pv[1], d_idx[1], d_chord[1]}, 32'h0);
        end

        // Single press on pin 2: commit exactly 12 clk after the raw edge
        raw[2] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            if (e == 11) check("b2_early", 32'(d_btn[0][2]), 32'h0);
        end
        check("b2_btn", 32'(d_btn[0]), 32'h4);
        check("b2_press", 32'(d_press[0]), 32'h4);
        check("b2_pv", 32'(d_pv[0]), 32'h1);
        check("b2_idx", 32'(d_idx[0]), 32'h2);
        check("b2_chord", 32'(d_chord[0]), 32'h0);
        check("b2_btn_lo", 32'(d_btn[1]), 32'h4);
        step(1);
        check("b2_press_gone", 32'(d_press[0]), 32'h0);
        check("b2_pv_gone", 32'(d_pv[0]), 32'h0);
        raw[2] = 1'b0;
        step(20);

        // Bouncing pin 0: only the final stable high commits, once
        pc = 0;
        for (int r = 0; r < 4; r++) begin
            raw[0] = 1'b1;
            for (int i = 0; i < 5; i++) begin step(1); pc += int'(d_press[0][0]); end
            raw[0] = 1'b0;
            for (int i = 0; i < 3; i++) begin step(1); pc += int'(d_press[0][0]); end
        end
        raw[0] = 1'b1;
        lat = 0;
        while (!d_btn[0][0] && lat < 40) begin
            step(1); lat++; pc += int'(d_press[0][0]);
        end
        check("bounce_lat", 32'(lat), 32'd12);
        check("bounce_lo_btn0", 32'(d_btn[1][0]), 32'h1);
        step(5);
        check("bounce_presses", 32'(pc), 32'd1);
        raw[0] = 1'b0;
        step(20);

        // Chord: 1 then 3 gives no second event; 3 alone afterwards does
        raw[1] = 1'b1;
        step(14);
        check("ch_b1", 32'(d_btn[0]), 32'h2);
        raw[3] = 1'b1;
        pvc = 0;
        for (int i = 0; i < 14; i++) begin step(1); pvc += int'(d_pv[0]); end
        check("ch_btn", 32'(d_btn[0]), 32'hA);
        check("ch_chord", 32'(d_chord[0]), 32'h1);
        check("ch_no_pv", 32'(pvc), 32'h0);
        raw = 4'h0;
        step(14);
        check("ch_rel", 32'(d_btn[0]), 32'h0);
        raw[3] = 1'b1;
        lat = 0;
        while (!d_pv[0] && lat < 40) begin step(1); lat++; end
        check("ch_pv3_lat", 32'(lat), 32'd12);
        check("ch_idx3", 32'(d_idx[0]), 32'h3);
        raw = 4'h0;
        step(20);

        // 64 clk per ms: commit window on press and release
        do_reset(6'd0);
        step($urandom_range(0, 100));
        raw[1] = 1'b1;
        lat = 0;
        while (!d_btn[0][1] && lat < 800) begin step(1); lat++; end
        check("slow_press_win", 32'((lat >= 578) && (lat <= 642)), 32'h1);
        check("slow_press_pulse", 32'(d_press[0]), 32'h2);
        step($urandom_range(0, 100));
        raw[1] = 1'b0;
        lat = 0;
        while (d_btn[0][1] && lat < 800) begin step(1); lat++; end
        check("slow_rel_win", 32'((lat >= 578) && (lat <= 642)), 32'h1);
        check("slow_rel_pulse", 32'(d_rel[0]), 32'h2);
        step(5);

        // Random bouncing with occasional mid-debounce reset
        for (int p = 0; p < 3; p++) begin
            do_reset(6'(p + 1));
            for (int cyc = 0; cyc < 1200; cyc += hold) begin
                raw = raw ^ 4'($urandom_range(1, 15));
                hold = $urandom_range(1, 14 * (p + 1));
                if ($urandom_range(0, 60) == 0) begin
                    rst = 1'b1;
                    step(1);
                    rst = 1'b0;
                end
                step(hold);
            end
        end
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
